ps2_rx_ctrl: RTL and testbench

Clock-domain PS/2 receive controller for the DE1 keyboard path. It samples the raw keyboard clock and data lines with the system clock, filters and edge-detects them, and runs the 11-bit frame state machine with parity, stop-bit and inter-edge timeout checks. Good bytes go into a small first-word-fall-through FIFO that the scan-code/7-segment logic drains. When the FIFO is full, the block optionally inhibits the keyboard by holding its clock line low.

---
 rtl/ps2_rx_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ps2_rx_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_rx_ctrl : PS/2 receiver with sync/filter, 11-bit frame FSM, timeout,   |
// |               FWFT byte FIFO; optional bus inhibit via PS2_INHIBIT_EN      |
// | Revision    : 1.0                                                          |
// +--------------------------------------------------------------------------+
module ps2_rx_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILT_LEN       = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       SCL,
  input  logic       SDA,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       empty,
  output logic       full,
  output logic       scl_oe,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       err_overflow
);
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_FW = $clog2(FILT_LEN) + 1;
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_FW-1:0] c_FILT_LAST = c_FW'(FILT_LEN - 1);
  localparam logic [c_TW-1:0] c_TMO       = c_TW'(TIMEOUT_CYCLES);
  localparam logic [c_AW:0]   c_FULL      = (c_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0] w_raw;
  logic [1:0] w_filt;
  assign w_raw = {SDA, SCL};

  // Channel 0 is SCL, channel 1 is SDA; both idle high.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_chan
      logic            r_s1, r_s2, r_f;
      logic [c_FW-1:0] r_cnt;
      always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
          r_s1  <= 1'b1;
          r_s2  <= 1'b1;
          r_f   <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_s1 <= w_raw[g];
          r_s2 <= r_s1;
          if (r_s2 == r_f) begin
            r_cnt <= '0;
          end else if (r_cnt == c_FILT_LAST) begin
            r_f   <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
      assign w_filt[g] = r_f;
    end
  endgenerate

  logic r_scl_d;
  logic w_fall, w_sda;
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) r_scl_d <= 1'b1;
    else      r_scl_d <= w_filt[0];
  end
  assign w_fall = r_scl_d & ~w_filt[0];
  assign w_sda  = w_filt[1];

  state_t          r_state;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [c_TW-1:0] r_tcnt;
  logic            r_push;
  logic [7:0]      r_push_data;
  logic            r_err_parity, r_err_frame, r_err_timeout, r_err_overflow;
  logic            w_inhibit, w_tmo;

  assign w_tmo = (r_state != S_IDLE) && !w_fall && (r_tcnt == c_TMO);

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state       <= S_IDLE;
      r_bitcnt      <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_tcnt        <= '0;
      r_push        <= 1'b0;
      r_push_data   <= '0;
      r_err_parity  <= 1'b0;
      r_err_frame   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_push        <= 1'b0;
      r_err_parity  <= 1'b0;
      r_err_frame   <= 1'b0;
      r_err_timeout <= 1'b0;
      if (w_fall || r_state == S_IDLE || w_inhibit) r_tcnt <= '0;
      else                                          r_tcnt <= r_tcnt + 1'b1;
      case (r_state)
        S_IDLE: if (w_fall && !w_sda) begin
          r_bitcnt <= '0;
          r_state  <= S_DATA;
        end
        S_DATA: if (w_fall) begin
          r_shift  <= {w_sda, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_bitcnt == 3'd7) r_state <= S_PARITY;
        end
        S_PARITY: if (w_fall) begin
          r_par   <= w_sda;
          r_state <= S_STOP;
        end
        S_STOP: if (w_fall) begin
          r_state <= S_IDLE;
          if (!(^{r_shift, r_par})) begin
            r_err_parity <= 1'b1;
          end else if (!w_sda) begin
            r_err_frame <= 1'b1;
          end else begin
            r_push      <= 1'b1;
            r_push_data <= r_shift;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_tmo) begin
        r_state       <= S_IDLE;
        r_shift       <= '0;
        r_err_timeout <= 1'b1;
      end
    end
  end

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wptr, r_rptr;
  logic [c_AW:0] r_count;
  logic          w_pop, w_wr;

  assign empty    = (r_count == '0);
  assign full     = (r_count == c_FULL);
  assign w_pop    = rd_en & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_wr     = r_push & (~full | w_pop);
  assign data_out = empty ? 8'h00 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_push_data;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      r_err_overflow <= r_push & full & ~w_pop;
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef PS2_INHIBIT_EN
  logic r_scl_oe;
  always_ff @(posedge clk or negedge RST) begin
    if (!RST)                   r_scl_oe <= 1'b0;
    else if (!full)             r_scl_oe <= 1'b0;
    else if (r_state == S_IDLE) r_scl_oe <= 1'b1;
  end
  assign w_inhibit = r_scl_oe;
`else
  assign w_inhibit = 1'b0;
`endif

  assign scl_oe       = w_inhibit;
  assign err_parity   = r_err_parity;
  assign err_frame    = r_err_frame;
  assign err_timeout  = r_err_timeout;
  assign err_overflow = r_err_overflow;
endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_rx_ctrl : keyboard-side frame generator with a byte-queue model     |
// | Revision       : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_ps2_rx_ctrl;
  localparam int TMO   = 200;
  localparam int HALF  = 20;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       RST = 1'b0;
  logic       SCL = 1'b1;
  logic       SDA = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       empty, full, scl_oe;
  logic       err_parity, err_frame, err_timeout, err_overflow;

  ps2_rx_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .FILT_LEN      (4),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .SCL         (SCL),
    .SDA         (SDA),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .empty       (empty),
    .full        (full),
    .scl_oe      (scl_oe),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_timeout (err_timeout),
    .err_overflow(err_overflow)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0, n_wide = 0;
  int e_par = 0, e_frm = 0, e_to = 0, e_ovf = 0;
  logic [7:0] q[$];
  logic [3:0] prev_err = 4'b0;

  // Pulse counters; any error held high two samples running is a width violation.
  always @(negedge clk) begin
    if (err_parity)   n_par++;
    if (err_frame)    n_frm++;
    if (err_timeout)  n_to++;
    if (err_overflow) n_ovf++;
    if (|({err_parity, err_frame, err_timeout, err_overflow} & prev_err)) n_wide++;
    prev_err = {err_parity, err_frame, err_timeout, err_overflow};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: what a correct receiver must do with one complete frame.
  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    if ((^d ^ par) == 1'b0)      e_par++;
    else if (!stop)              e_frm++;
    else if (q.size() < DEPTH)   q.push_back(d);
    else                         e_ovf++;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      SDA = bits[i];
      tick(HALF);
      if (i == glitch_at) begin
        SCL = 1'b0;
        tick(2);
        SCL = 1'b1;
        tick(HALF);
      end
      SCL = 1'b0;
      tick(HALF);
      SCL = 1'b1;
    end
    SDA = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                            input int glitch_at);
    logic par;
    par = (~^d) ^ par_flip;
    send_bits({stop, par, d, 1'b0}, 11, glitch_at);
    tick(3 * HALF);
    model_frame(d, par, stop);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".par"},   n_par, e_par);
    check({tag, ".frm"},   n_frm, e_frm);
    check({tag, ".to"},    n_to,  e_to);
    check({tag, ".ovf"},   n_ovf, e_ovf);
    check({tag, ".empty"}, empty, (q.size() == 0));
    check({tag, ".full"},  full,  (q.size() == DEPTH));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) break;
      check("drain.empty", empty, 1'b0);
      check("drain.data", data_out, q[0]);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      void'(q.pop_front());
    end
    tick(1);
    check("drain.after", empty, (q.size() == 0));
  endtask

  initial begin
    int kind;
    logic [7:0] d;

    tick(5);
    check("rst.data", data_out, 8'h00);
    check("rst.empty", empty, 1'b1);
    check("rst.full", full, 1'b0);
    check("rst.oe", scl_oe, 1'b0);
    check("rst.errs", {err_parity, err_frame, err_timeout, err_overflow}, 4'b0);
    RST = 1'b1;
    tick(5);

    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check_state("f1c");
    check("f1c.data", data_out, 8'h1C);
    drain(1);

    send_frame(8'h1C, 1'b1, 1'b1, -1);
    check_state("bad_par");
    send_frame(8'hF0, 1'b0, 1'b0, -1);
    check_state("bad_stop");

    // Start bit plus four data bits, then the clock stops.
    send_bits({6'b0, 4'b0101, 1'b0}, 5, -1);
    tick(TMO - HALF - 20);
    check("to.early", n_to, e_to);
    tick(60);
    e_to++;
    check_state("timeout");
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    check_state("after_to");
    drain(1);

    // Start-like glitch in idle, then a glitch inside a frame.
    SDA = 1'b0;
    SCL = 1'b0;
    tick(2);
    SCL = 1'b1;
    tick(HALF);
    SDA = 1'b1;
    tick(HALF);
    send_frame(8'hE0, 1'b0, 1'b1, 4);
    check_state("glitch");
    drain(1);

    for (int n = 0; n < 12; n++) begin
      kind = $urandom_range(0, 3);
      d = 8'($urandom);
      send_frame(d, (kind == 0), (kind != 1), -1);
      check_state("rand");
      if (q.size() >= DEPTH - 2) drain(q.size());
    end
    drain(q.size());

    for (int n = 1; n <= 8; n++) send_frame(8'(n), 1'b0, 1'b1, -1);
    check_state("fill8");
`ifdef PS2_INHIBIT_EN
    check("inh.oe_on", scl_oe, 1'b1);
    drain(1);
    tick(2);
    check("inh.oe_off", scl_oe, 1'b0);
`else
    check("noinh.oe", scl_oe, 1'b0);
    send_frame(8'h09, 1'b0, 1'b1, -1);
    check_state("ovf");
`endif
    drain(q.size());

    send_frame(8'h33, 1'b0, 1'b1, -1);
    send_bits({5'b0, 5'b00101, 1'b0}, 6, -1);
    RST = 1'b0;
    tick(3);
    q.delete();
    check("mid_rst.empty", empty, 1'b1);
    check("mid_rst.data", data_out, 8'h00);
    check("mid_rst.full", full, 1'b0);
    RST = 1'b1;
    tick(5);
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    check_state("after_rst");
    check("after_rst.data", data_out, 8'h5A);
    drain(1);

    check("pulse_width", n_wide, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
